uart_tx_engine: RTL

UART transmit engine for the CECS-460 SoC. It accepts a byte from the processor, builds the serial frame (start, 7/8 data bits, optional parity, stop), and generates the bit-time pulse from a selectable baud divisor. It shifts the frame out LSB-first on `tx`. It sits alongside the bit counter: it drives the counter's `doit` and `btu` inputs and consumes its `done` output to end each frame.

---
 rtl/uart_tx_engine_if.sv | 41 ++++
 rtl/uart_tx_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine_if.sv
// -----------------------------------------------------------------------------
// uart_tx_engine_if
// Processor-side bus of the UART transmit engine.
//   load      : one-cycle write strobe (processor -> engine)
//   out_port  : byte to transmit          (processor -> engine)
//   eight     : 1 = 8 data bits, 0 = 7    (processor -> engine)
//   pen       : parity enable             (processor -> engine)
//   ohel      : parity sense, 1 = odd     (processor -> engine)
//   baud_sel  : baud rate select          (processor -> engine)
//   txrdy     : engine ready for a byte   (engine -> processor)
// The master modport is the processor; the slave modport is the engine.
// -----------------------------------------------------------------------------
interface uart_tx_engine_if;
  logic       load;
  logic [7:0] out_port;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic [3:0] baud_sel;
  logic       txrdy;

  modport master (
    output load,
    output out_port,
    output eight,
    output pen,
    output ohel,
    output baud_sel,
    input  txrdy
  );

  modport slave (
    input  load,
    input  out_port,
    input  eight,
    input  pen,
    input  ohel,
    input  baud_sel,
    output txrdy
  );
endinterface

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// Builds an 11-bit UART frame (start, 7/8 data bits, optional parity, stop
// padding) from a processor byte and shifts it out LSB-first on tx_o, timing
// each bit with a divisor selected by baud_sel. Works with an external bit
// counter: doit_o enables it, btu_o clocks it, done_i ends the frame.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : processor bus (load/out_port/format/baud_sel in, txrdy out)
//   done_i   : bit counter reports 11 bit-times elapsed (registered)
//   doit_o   : frame in progress, enables the bit counter
//   btu_o    : one-cycle bit-time-up pulse, only while doit_o is high
//   tx_o     : serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_engine #(
  parameter int unsigned CLK_HZ = 32'd100000000
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_engine_if.slave        bus,
  input  logic                   done_i,
  output logic                   doit_o,
  output logic                   btu_o,
  output logic                   tx_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Bit-time terminal counts (divisor - 1), rounded to the nearest clock.
  // At 100 MHz these give 333333, 83333, 41667, 20833, 10417, 5208, 2604,
  // 1736, 868, 434, 217 and 109 clocks per bit.
  localparam logic [18:0] M1_300    = 19'((CLK_HZ + 32'd150)    / 32'd300    - 32'd1);
  localparam logic [18:0] M1_1200   = 19'((CLK_HZ + 32'd600)    / 32'd1200   - 32'd1);
  localparam logic [18:0] M1_2400   = 19'((CLK_HZ + 32'd1200)   / 32'd2400   - 32'd1);
  localparam logic [18:0] M1_4800   = 19'((CLK_HZ + 32'd2400)   / 32'd4800   - 32'd1);
  localparam logic [18:0] M1_9600   = 19'((CLK_HZ + 32'd4800)   / 32'd9600   - 32'd1);
  localparam logic [18:0] M1_19200  = 19'((CLK_HZ + 32'd9600)   / 32'd19200  - 32'd1);
  localparam logic [18:0] M1_38400  = 19'((CLK_HZ + 32'd19200)  / 32'd38400  - 32'd1);
  localparam logic [18:0] M1_57600  = 19'((CLK_HZ + 32'd28800)  / 32'd57600  - 32'd1);
  localparam logic [18:0] M1_115200 = 19'((CLK_HZ + 32'd57600)  / 32'd115200 - 32'd1);
  localparam logic [18:0] M1_230400 = 19'((CLK_HZ + 32'd115200) / 32'd230400 - 32'd1);
  localparam logic [18:0] M1_460800 = 19'((CLK_HZ + 32'd230400) / 32'd460800 - 32'd1);
  localparam logic [18:0] M1_921600 = 19'((CLK_HZ + 32'd460800) / 32'd921600 - 32'd1);

  // Terminal count for a baud select; unused selects fall back to 9600.
  function automatic logic [18:0] div_m1_f(input logic [3:0] sel);
    logic [18:0] m1;
    case (sel)
      4'd0:    m1 = M1_300;
      4'd1:    m1 = M1_1200;
      4'd2:    m1 = M1_2400;
      4'd3:    m1 = M1_4800;
      4'd4:    m1 = M1_9600;
      4'd5:    m1 = M1_19200;
      4'd6:    m1 = M1_38400;
      4'd7:    m1 = M1_57600;
      4'd8:    m1 = M1_115200;
      4'd9:    m1 = M1_230400;
      4'd10:   m1 = M1_460800;
      4'd11:   m1 = M1_921600;
      default: m1 = M1_9600;
    endcase
    return m1;
  endfunction

  // Parity over the transmitted data bits only; bit 7 counts only in 8-bit mode.
  function automatic logic parity_f(input logic [7:0] data, input logic eight,
                                    input logic ohel);
    logic x;
    x = (^data[6:0]) ^ (eight & data[7]);
    return x ^ ohel;
  endfunction

  // Frame image, bit 0 (start) leaves first; unused top bits are stop-level 1s.
  function automatic logic [10:0] frame_f(input logic [7:0] data, input logic eight,
                                          input logic pen, input logic ohel);
    logic        p;
    logic [10:0] f;
    p = parity_f(data, eight, ohel);
    case ({eight, pen})
      2'b11:   f = {1'b1, p, data[7:0], 1'b0};
      2'b10:   f = {1'b1, 1'b1, data[7:0], 1'b0};
      2'b01:   f = {1'b1, 1'b1, p, data[6:0], 1'b0};
      2'b00:   f = {1'b1, 1'b1, 1'b1, data[6:0], 1'b0};
      default: f = 11'h7FF;
    endcase
    return f;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        eight_q, eight_d;
  logic        pen_q, pen_d;
  logic        ohel_q, ohel_d;
  logic [3:0]  baud_q, baud_d;
  logic [10:0] sr_q, sr_d;
  logic [18:0] cnt_q, cnt_d;
  logic        doit_q, doit_d;
  logic        btu_q, btu_d;
  logic        txrdy_q, txrdy_d;
  logic [18:0] div_m1_s;

  assign div_m1_s = div_m1_f(baud_q);

  // Next-state logic: frame FSM, shift register and bit-time counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    eight_d = eight_q;
    pen_d   = pen_q;
    ohel_d  = ohel_q;
    baud_d  = baud_q;
    sr_d    = sr_q;
    doit_d  = doit_q;
    txrdy_d = txrdy_q;
    cnt_d   = 19'd0;
    btu_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          data_d  = bus.out_port;
          eight_d = bus.eight;
          pen_d   = bus.pen;
          ohel_d  = bus.ohel;
          baud_d  = bus.baud_sel;
          txrdy_d = 1'b0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        sr_d    = frame_f(data_q, eight_q, pen_q, ohel_q);
        doit_d  = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (done_i) begin
          sr_d    = 11'h7FF;
          doit_d  = 1'b0;
          txrdy_d = 1'b1;
          state_d = ST_IDLE;
        end else if (btu_q) begin
          sr_d = {1'b1, sr_q[10:1]};
        end else begin
          sr_d = sr_q;
        end
      end
      default: begin
        sr_d    = 11'h7FF;
        doit_d  = 1'b0;
        txrdy_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // The count starts at 0 in the first cycle doit is high and is held at 0
    // otherwise; btu is registered so it is high exactly while count == DIV-1.
    if (!doit_q || !doit_d) begin
      cnt_d = 19'd0;
    end else if (cnt_q == div_m1_s) begin
      cnt_d = 19'd0;
    end else begin
      cnt_d = cnt_q + 19'd1;
    end
    btu_d = doit_d & (cnt_d == div_m1_s);
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      baud_q  <= 4'd0;
      sr_q    <= 11'h7FF;
      cnt_q   <= 19'd0;
      doit_q  <= 1'b0;
      btu_q   <= 1'b0;
      txrdy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      eight_q <= eight_d;
      pen_q   <= pen_d;
      ohel_q  <= ohel_d;
      baud_q  <= baud_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      doit_q  <= doit_d;
      btu_q   <= btu_d;
      txrdy_q <= txrdy_d;
    end
  end

  assign tx_o      = sr_q[0];
  assign doit_o    = doit_q;
  assign btu_o     = btu_q;
  assign bus.txrdy = txrdy_q;

endmodule
